// File: rtl/motor_pkg.sv
// Shared types and constants for the motor position controller.
`timescale 1ns/1ps
package motor_pkg;

  typedef enum logic [1:0] {IDLE, DEAD, RUN, FAULT} state_t;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_ACW = 1'b1;

endpackage

// File: rtl/hall_filter.sv
// Hall sensor conditioning: two-flop synchroniser, debounce, and one-cycle
// pulse on each accepted rising edge of the filtered level.
`timescale 1ns/1ps
module hall_filter #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_hall,
  output logic o_pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  // The level flips only after DEB_CYCLES consecutive clocks of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync0 <= i_hall;
      r_sync1 <= r_sync0;
      r_pulse <= 1'b0;
      if (r_sync1 != r_level) begin
        if (r_cnt == DEB_LAST) begin
          r_level <= r_sync1;
          r_cnt   <= '0;
          r_pulse <= r_sync1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/motor_pos_ctrl.sv
// Single-motor position controller: runs the H-bridge in the commanded
// direction for a number of debounced hall pulses, with dead time and stall.
`timescale 1ns/1ps
module motor_pos_ctrl
  import motor_pkg::*;
#(
  parameter int COUNT_W      = 11,
  parameter int DEB_CYCLES   = 1000,
  parameter int STALL_CYCLES = 1_000_000,
  parameter int DEAD_CYCLES  = 50_000
) (
  input  logic               CLK_50,
  input  logic               Reset,
  input  logic               hallIn,
  input  logic               cmd_valid,
  input  logic               cmd_dir,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic               abort,
  output logic               cmd_ready,
  output logic               motorCW,
  output logic               motorACW,
  output logic               busy,
  output logic               done,
  output logic               stall,
  output logic [COUNT_W-1:0] pulses_left
);

  localparam int DEAD_W  = $clog2(DEAD_CYCLES + 1);
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [DEAD_W-1:0]  DEAD_LAST  = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

  logic w_pulse;

  hall_filter #(.DEB_CYCLES(DEB_CYCLES)) u_hall (
    .clk     (CLK_50),
    .rst     (Reset),
    .i_hall  (hallIn),
    .o_pulse (w_pulse)
  );

  state_t               r_state;
  logic                 r_dir;
  logic                 r_lastDir;
  logic [COUNT_W-1:0]   r_left;
  logic [DEAD_W-1:0]    r_deadCnt;
  logic [STALL_W-1:0]   r_stallCnt;
  logic                 r_ready;
  logic                 r_cw;
  logic                 r_acw;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_stall;

  // Every output is a register updated on the transition that changes it.
  always_ff @(posedge CLK_50) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_dir      <= DIR_CW;
      r_lastDir  <= DIR_CW;
      r_left     <= '0;
      r_deadCnt  <= '0;
      r_stallCnt <= '0;
      r_ready    <= 1'b1;
      r_cw       <= 1'b0;
      r_acw      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_stall    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!abort && cmd_valid) begin
            r_dir  <= cmd_dir;
            r_left <= cmd_count;
            if (cmd_count == '0) begin
              r_done <= 1'b1;
            end else if (cmd_dir != r_lastDir) begin
              r_state   <= DEAD;
              r_deadCnt <= '0;
              r_busy    <= 1'b1;
              r_ready   <= 1'b0;
            end else begin
              r_state    <= RUN;
              r_stallCnt <= '0;
              r_busy     <= 1'b1;
              r_ready    <= 1'b0;
              r_cw       <= (cmd_dir == DIR_CW);
              r_acw      <= (cmd_dir == DIR_ACW);
            end
          end
        end
        DEAD: begin
          if (abort) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_lastDir <= r_dir;
          end else if (r_deadCnt == DEAD_LAST) begin
            r_state    <= RUN;
            r_stallCnt <= '0;
            r_cw       <= (r_dir == DIR_CW);
            r_acw      <= (r_dir == DIR_ACW);
          end else begin
            r_deadCnt <= r_deadCnt + 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            r_state   <= IDLE;
            r_cw      <= 1'b0;
            r_acw     <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_lastDir <= r_dir;
          end else if (w_pulse && r_left != '0) begin
            // A counted edge beats a simultaneous stall expiry.
            r_left     <= r_left - 1'b1;
            r_stallCnt <= '0;
            if (r_left == COUNT_W'(1)) begin
              r_state   <= IDLE;
              r_cw      <= 1'b0;
              r_acw     <= 1'b0;
              r_busy    <= 1'b0;
              r_ready   <= 1'b1;
              r_done    <= 1'b1;
              r_lastDir <= r_dir;
            end
          end else if (r_stallCnt == STALL_LAST) begin
            r_state <= FAULT;
            r_cw    <= 1'b0;
            r_acw   <= 1'b0;
            r_busy  <= 1'b0;
            r_stall <= 1'b1;
          end else begin
            r_stallCnt <= r_stallCnt + 1'b1;
          end
        end
        FAULT: begin
          if (abort) begin
            r_state <= IDLE;
            r_stall <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_ready;
  assign motorCW     = r_cw;
  assign motorACW    = r_acw;
  assign busy        = r_busy;
  assign done        = r_done;
  assign stall       = r_stall;
  assign pulses_left = r_left;

endmodule

// File: tb/tb_motor_pos_ctrl.sv
// Directed bench for motor_pos_ctrl: table of moves plus hand-written
// stall, abort and zero-count sequences.
`timescale 1ns/1ps
module tb_motor_pos_ctrl;

  localparam int COUNT_W = 11;
  localparam int DEB     = 4;
  localparam int STALLC  = 200;
  localparam int DEADC   = 10;

  logic               CLK_50 = 1'b0;
  logic               Reset;
  logic               hallIn;
  logic               cmd_valid;
  logic               cmd_dir;
  logic [COUNT_W-1:0] cmd_count;
  logic               abort;
  logic               cmd_ready;
  logic               motorCW;
  logic               motorACW;
  logic               busy;
  logic               done;
  logic               stall;
  logic [COUNT_W-1:0] pulses_left;

  motor_pos_ctrl #(
    .COUNT_W(COUNT_W), .DEB_CYCLES(DEB), .STALL_CYCLES(STALLC), .DEAD_CYCLES(DEADC)
  ) dut (
    .CLK_50(CLK_50), .Reset(Reset), .hallIn(hallIn), .cmd_valid(cmd_valid),
    .cmd_dir(cmd_dir), .cmd_count(cmd_count), .abort(abort), .cmd_ready(cmd_ready),
    .motorCW(motorCW), .motorACW(motorACW), .busy(busy), .done(done),
    .stall(stall), .pulses_left(pulses_left)
  );

  always #10 CLK_50 = ~CLK_50;

  int   total = 0;
  int   bad = 0;
  logic hallRun = 1'b0;
  logic hallGlitch = 1'b0;
  logic hallBusy = 1'b0;
  int   realEdges = 0;

  // Hall generator: 40-clock period, optional 2-clock glitch in the low half.
  initial begin
    hallIn = 1'b0;
    forever begin
      @(negedge CLK_50);
      if (hallRun) begin
        hallBusy = 1'b1;
        hallIn = 1'b1;
        realEdges++;
        repeat (20) @(negedge CLK_50);
        hallIn = 1'b0;
        if (hallGlitch) begin
          repeat (8) @(negedge CLK_50);
          hallIn = 1'b1;
          repeat (2) @(negedge CLK_50);
          hallIn = 1'b0;
          repeat (9) @(negedge CLK_50);
        end else begin
          repeat (19) @(negedge CLK_50);
        end
        hallBusy = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic dir;
    int   cnt;
    logic glitch;
    logic expDead;
    logic expCW;
    logic expACW;
  } move_t;

  move_t moves[4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic dir, input logic [COUNT_W-1:0] cnt, input logic ab);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_count = cnt;
    abort     = ab;
    @(negedge CLK_50);
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic pulseAbort();
    abort = 1'b1;
    @(negedge CLK_50);
    abort = 1'b0;
  endtask

  task automatic waitHallIdle();
    hallRun = 1'b0;
    for (int i = 0; i < 100 && hallBusy; i++) @(negedge CLK_50);
    repeat (10) @(negedge CLK_50);
  endtask

  initial begin
    logic seen;
    int   n;
    int   doneCount;

    moves[0] = '{dir: 1'b1, cnt: 15, glitch: 1'b0, expDead: 1'b1, expCW: 1'b0, expACW: 1'b1};
    moves[1] = '{dir: 1'b0, cnt: 3,  glitch: 1'b0, expDead: 1'b1, expCW: 1'b1, expACW: 1'b0};
    moves[2] = '{dir: 1'b0, cnt: 5,  glitch: 1'b1, expDead: 1'b0, expCW: 1'b1, expACW: 1'b0};
    moves[3] = '{dir: 1'b1, cnt: 4,  glitch: 1'b0, expDead: 1'b1, expCW: 1'b0, expACW: 1'b1};

    Reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir = 1'b0;
    cmd_count = '0;
    abort = 1'b0;
    repeat (5) @(negedge CLK_50);
    Reset = 1'b0;
    @(negedge CLK_50);
    checkOutput("reset_drive", 32'({motorCW, motorACW}), 0);
    checkOutput("reset_flags", 32'({busy, done, stall}), 0);
    checkOutput("reset_ready", 32'(cmd_ready), 1);
    checkOutput("reset_left", 32'(pulses_left), 0);

    foreach (moves[k]) begin
      waitHallIdle();
      hallGlitch = moves[k].glitch;
      realEdges = 0;
      applyStimulus(moves[k].dir, COUNT_W'(moves[k].cnt), 1'b0);
      checkOutput("move_ready_low", 32'(cmd_ready), 0);
      checkOutput("move_busy", 32'(busy), 1);
      if (moves[k].expDead) begin
        checkOutput("dead_start_off", 32'({motorCW, motorACW}), 0);
        repeat (DEADC - 1) @(negedge CLK_50);
        checkOutput("dead_end_off", 32'({motorCW, motorACW}), 0);
        @(negedge CLK_50);
      end
      checkOutput("move_drive", 32'({motorCW, motorACW}), 32'({moves[k].expCW, moves[k].expACW}));
      hallRun = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < moves[k].cnt * 40 + 100 && !seen; i++) begin
        @(negedge CLK_50);
        if (done) seen = 1'b1;
      end
      hallRun = 1'b0;
      checkOutput("move_done_seen", 32'(seen), 1);
      checkOutput("move_end_drive", 32'({motorCW, motorACW}), 0);
      checkOutput("move_end_busy", 32'(busy), 0);
      checkOutput("move_end_left", 32'(pulses_left), 0);
      checkOutput("move_edges", 32'(realEdges), 32'(moves[k].cnt));
      @(negedge CLK_50);
      checkOutput("move_done_one_cycle", 32'(done), 0);
    end

    // Stall: two edges then silence, last direction is anticlockwise.
    waitHallIdle();
    hallGlitch = 1'b0;
    realEdges = 0;
    applyStimulus(1'b1, COUNT_W'(8), 1'b0);
    checkOutput("stall_drive", 32'({motorCW, motorACW}), 1);
    hallRun = 1'b1;
    for (int i = 0; i < 200 && realEdges < 2; i++) @(negedge CLK_50);
    hallRun = 1'b0;
    for (int i = 0; i < 100 && pulses_left != COUNT_W'(6); i++) @(negedge CLK_50);
    checkOutput("stall_left_before", 32'(pulses_left), 6);
    n = 0;
    for (int i = 0; i < 400 && !stall; i++) begin
      @(negedge CLK_50);
      n++;
    end
    checkOutput("stall_delay", 32'(n), STALLC);
    checkOutput("stall_flag", 32'(stall), 1);
    checkOutput("stall_drive_off", 32'({motorCW, motorACW}), 0);
    checkOutput("stall_busy", 32'(busy), 0);
    checkOutput("stall_left", 32'(pulses_left), 6);
    applyStimulus(1'b0, COUNT_W'(3), 1'b0);
    checkOutput("fault_ignore_cmd_stall", 32'(stall), 1);
    checkOutput("fault_ignore_cmd_ready", 32'(cmd_ready), 0);
    checkOutput("fault_ignore_cmd_left", 32'(pulses_left), 6);
    pulseAbort();
    checkOutput("fault_abort_stall", 32'(stall), 0);
    checkOutput("fault_abort_ready", 32'(cmd_ready), 1);

    // Abort mid-run after four counted edges.
    waitHallIdle();
    realEdges = 0;
    applyStimulus(1'b1, COUNT_W'(10), 1'b0);
    for (int i = 0; i < DEADC + 5 && !motorACW; i++) @(negedge CLK_50);
    checkOutput("abort_drive_on", 32'({motorCW, motorACW}), 1);
    hallRun = 1'b1;
    for (int i = 0; i < 400 && pulses_left != COUNT_W'(6); i++) @(negedge CLK_50);
    repeat (3) @(negedge CLK_50);
    applyStimulus(1'b0, COUNT_W'(2), 1'b0);
    checkOutput("busy_ignore_left", 32'(pulses_left), 6);
    checkOutput("busy_ignore_drive", 32'({motorCW, motorACW}), 1);
    pulseAbort();
    hallRun = 1'b0;
    checkOutput("abort_drive_off", 32'({motorCW, motorACW}), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_no_done", 32'(done), 0);
    checkOutput("abort_left", 32'(pulses_left), 6);
    checkOutput("abort_ready", 32'(cmd_ready), 1);
    doneCount = 0;
    repeat (5) begin
      @(negedge CLK_50);
      if (done) doneCount++;
    end
    checkOutput("abort_no_late_done", 32'(doneCount), 0);

    // Zero-count command completes immediately with no drive.
    waitHallIdle();
    applyStimulus(1'b0, COUNT_W'(0), 1'b0);
    checkOutput("zero_done", 32'(done), 1);
    checkOutput("zero_drive", 32'({motorCW, motorACW}), 0);
    checkOutput("zero_busy", 32'(busy), 0);
    checkOutput("zero_left", 32'(pulses_left), 0);
    @(negedge CLK_50);
    checkOutput("zero_done_one_cycle", 32'(done), 0);

    // Abort and command together in idle: command is dropped.
    applyStimulus(1'b1, COUNT_W'(5), 1'b1);
    checkOutput("abort_wins_ready", 32'(cmd_ready), 1);
    checkOutput("abort_wins_busy", 32'(busy), 0);
    checkOutput("abort_wins_left", 32'(pulses_left), 0);
    checkOutput("abort_wins_done", 32'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
